// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared constants and helpers for the Sobol sequence generator
//
// Contents:
//   SOBOL_WIDTH     default sample/counter width
//   SOBOL_LOGWIDTH  default direction-vector index width ($clog2(SOBOL_WIDTH))
//   default_dv()    reset value of direction vector k (van der Corput: 1 << (width-1-k))

package sobol_pkg;

    localparam int SOBOL_WIDTH    = 8;
    localparam int SOBOL_LOGWIDTH = 3;

    // Returned as 64 bits so any WIDTH up to 64 can slice the result.
    function automatic longint unsigned default_dv(input int k, input int width);
        return 64'd1 << (width - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_lsz.sv
// rtl/sobol_lsz.sv - least-significant-zero index of the Sobol counter
//
// Ports:
//   cnt      in   WIDTH     counter value
//   lsz_idx  out  LOGWIDTH  lowest bit position of cnt that is 0; WIDTH-1 when cnt is all ones

module sobol_lsz
    import sobol_pkg::*;
#(
    parameter int WIDTH    = SOBOL_WIDTH,
    parameter int LOGWIDTH = SOBOL_LOGWIDTH
) (
    input  logic [WIDTH-1:0]    cnt,
    output logic [LOGWIDTH-1:0] lsz_idx
);

    // Scan from the top down so the lowest zero bit is the last assignment
    // that sticks. The all-ones case falls through to the default, which is
    // also the direction vector the wrap step would otherwise have used.
    always_comb begin
        lsz_idx = LOGWIDTH'(WIDTH - 1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!cnt[i]) begin
                lsz_idx = LOGWIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/sobol_seq_gen.sv
// rtl/sobol_seq_gen.sv - Gray-code Sobol low-discrepancy sequence generator
//
// Ports:
//   clk         in   1         clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   enable      in   1         advance the sequence by one sample
//   clear       in   1         synchronous restart to sample 0 (wins over enable)
//   dv_wr_en    in   1         direction-vector write strobe
//   dv_wr_addr  in   LOGWIDTH  direction-vector index (writes at addr >= WIDTH are dropped)
//   dv_wr_data  in   WIDTH     direction-vector value
//   out         out  WIDTH     current Sobol sample (registered)
//   lsz_idx     out  LOGWIDTH  least-significant-zero index of the counter
//   wrap        out  1         one-cycle pulse after the sequence wrapped to 0

module sobol_seq_gen
    import sobol_pkg::*;
#(
    parameter int WIDTH    = SOBOL_WIDTH,
    parameter int LOGWIDTH = SOBOL_LOGWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic                dv_wr_en,
    input  logic [LOGWIDTH-1:0] dv_wr_addr,
    input  logic [WIDTH-1:0]    dv_wr_data,
    output logic [WIDTH-1:0]    out,
    output logic [LOGWIDTH-1:0] lsz_idx,
    output logic                wrap
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dv [WIDTH];

    logic cnt_full;
    logic advance;
    logic dv_wr_hit;

    sobol_lsz #(
        .WIDTH    (WIDTH),
        .LOGWIDTH (LOGWIDTH)
    ) u_lsz (
        .cnt     (cnt),
        .lsz_idx (lsz_idx)
    );

    assign cnt_full  = &cnt;
    assign advance   = enable && !clear;
    // The index port can address past the vector file when WIDTH is not a
    // power of two; those writes are dropped rather than aliased.
    assign dv_wr_hit = dv_wr_en && (int'(dv_wr_addr) < WIDTH);

    // Counter, sample and wrap flag. On the last count the sample is forced
    // to 0 instead of XORing V[WIDTH-1], so the next period starts cleanly
    // at sample 0 with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            out  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            out  <= '0;
            wrap <= 1'b0;
        end else if (advance) begin
            if (cnt_full) begin
                cnt  <= '0;
                out  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + WIDTH'(1);
                out  <= out ^ dv[lsz_idx];
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Direction-vector file. A write in the same cycle as an advance lands
    // on the edge, so the XOR above still sees the old vector. clear leaves
    // the vectors alone; only reset restores the defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIDTH; k++) begin
                dv[k] <= WIDTH'(default_dv(k, WIDTH));
            end
        end else if (dv_wr_hit) begin
            dv[dv_wr_addr] <= dv_wr_data;
        end
    end

endmodule

// File: tb/tb_sobol_seq_gen.sv
// tb/tb_sobol_seq_gen.sv - self-checking bench for sobol_seq_gen

module tb_sobol_seq_gen;

    localparam int AW = 4;
    localparam int AL = 2;
    localparam int BW = 6;
    localparam int BL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_en = 0, a_clr = 0, a_wen = 0;
    logic [AL-1:0] a_waddr = '0;
    logic [AW-1:0] a_wdata = '0;
    logic [AW-1:0] a_out;
    logic [AL-1:0] a_lsz;
    logic          a_wrap;

    logic          b_en = 0, b_clr = 0, b_wen = 0;
    logic [BL-1:0] b_waddr = '0;
    logic [BW-1:0] b_wdata = '0;
    logic [BW-1:0] b_out;
    logic [BL-1:0] b_lsz;
    logic          b_wrap;

    sobol_seq_gen #(.WIDTH(AW), .LOGWIDTH(AL)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (a_en),
        .clear      (a_clr),
        .dv_wr_en   (a_wen),
        .dv_wr_addr (a_waddr),
        .dv_wr_data (a_wdata),
        .out        (a_out),
        .lsz_idx    (a_lsz),
        .wrap       (a_wrap)
    );

    sobol_seq_gen #(.WIDTH(BW), .LOGWIDTH(BL)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (b_en),
        .clear      (b_clr),
        .dv_wr_en   (b_wen),
        .dv_wr_addr (b_waddr),
        .dv_wr_data (b_wdata),
        .out        (b_out),
        .lsz_idx    (b_lsz),
        .wrap       (b_wrap)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic          en;
        logic          clr;
        logic          wen;
        logic [AL-1:0] waddr;
        logic [AW-1:0] wdata;
        logic [AW-1:0] eout;
        logic [AL-1:0] elsz;
        logic          ewrap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic clr, input logic wen,
                                input int waddr, input int wdata,
                                input int eout, input int elsz, input logic ewrap);
        vec_t v;
        v.en = en; v.clr = clr; v.wen = wen;
        v.waddr = AL'(waddr); v.wdata = AW'(wdata);
        v.eout = AW'(eout); v.elsz = AL'(elsz); v.ewrap = ewrap;
        return v;
    endfunction

    // Drive one cycle on dut_a, then check after the edge.
    task automatic step_a(input vec_t v, input string tag);
        a_en = v.en; a_clr = v.clr; a_wen = v.wen; a_waddr = v.waddr; a_wdata = v.wdata;
        @(posedge clk);
        #2;
        check({tag, ".out"},  32'(a_out),  32'(v.eout));
        check({tag, ".lsz"},  32'(a_lsz),  32'(v.elsz));
        check({tag, ".wrap"}, 32'(a_wrap), 32'(v.ewrap));
    endtask

    task automatic idle_all();
        a_en = 0; a_clr = 0; a_wen = 0;
        b_en = 0; b_clr = 0; b_wen = 0;
    endtask

    // Leaves time at posedge+2 with rst_n released; the next edge is the first live one.
    task automatic do_reset();
        idle_all();
        #3 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Reference model for dut_b: the sequence rules written as plain arithmetic.
    logic [BW-1:0] mv [BW];
    int            mcnt;
    logic [BW-1:0] mout;
    logic          mwrap;

    function automatic int trailing_ones(input int c);
        int k = 0;
        while (k < BW - 1 && c[k]) k++;
        return k;
    endfunction

    initial begin
        // Full period and wrap, then restart with no bubble, idle hold, clear,
        // and write coinciding with clear.
        tbl.push_back(mk(1,0,0,0,0,  8,1,0));
        tbl.push_back(mk(1,0,0,0,0, 12,0,0));
        tbl.push_back(mk(1,0,0,0,0,  4,2,0));
        tbl.push_back(mk(1,0,0,0,0,  6,0,0));
        tbl.push_back(mk(1,0,0,0,0, 14,1,0));
        tbl.push_back(mk(1,0,0,0,0, 10,0,0));
        tbl.push_back(mk(1,0,0,0,0,  2,3,0));
        tbl.push_back(mk(1,0,0,0,0,  3,0,0));
        tbl.push_back(mk(1,0,0,0,0, 11,1,0));
        tbl.push_back(mk(1,0,0,0,0, 15,0,0));
        tbl.push_back(mk(1,0,0,0,0,  7,2,0));
        tbl.push_back(mk(1,0,0,0,0,  5,0,0));
        tbl.push_back(mk(1,0,0,0,0, 13,1,0));
        tbl.push_back(mk(1,0,0,0,0,  9,0,0));
        tbl.push_back(mk(1,0,0,0,0,  1,3,0));
        tbl.push_back(mk(1,0,0,0,0,  0,0,1));
        tbl.push_back(mk(1,0,0,0,0,  8,1,0));
        tbl.push_back(mk(0,0,0,0,0,  8,1,0));
        tbl.push_back(mk(0,0,0,0,0,  8,1,0));
        tbl.push_back(mk(1,0,0,0,0, 12,0,0));
        tbl.push_back(mk(1,0,0,0,0,  4,2,0));
        tbl.push_back(mk(1,0,0,0,0,  6,0,0));
        tbl.push_back(mk(1,0,0,0,0, 14,1,0));
        tbl.push_back(mk(1,1,0,0,0,  0,0,0));
        tbl.push_back(mk(1,0,0,0,0,  8,1,0));
        tbl.push_back(mk(1,1,1,0,3,  0,0,0));
        tbl.push_back(mk(1,0,0,0,0,  3,1,0));
        tbl.push_back(mk(1,0,0,0,0,  7,0,0));
        tbl.push_back(mk(1,0,0,0,0,  4,2,0));

        do_reset();
        check("reset.out",  32'(a_out),  0);
        check("reset.lsz",  32'(a_lsz),  0);
        check("reset.wrap", 32'(a_wrap), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Write V[0] together with an advance: the old vector is used first.
        do_reset();
        step_a(mk(1,0,1,0,3,  8,1,0), "wradv0");
        step_a(mk(1,0,0,0,0, 12,0,0), "wradv1");
        step_a(mk(1,0,0,0,0, 15,2,0), "wradv2");

        // Async reset mid-cycle after loading V[1]=F discards state and vectors.
        do_reset();
        step_a(mk(0,0,1,1,15, 0,0,0), "arst_load");
        step_a(mk(1,0,0,0,0,  8,1,0), "arst_adv0");
        step_a(mk(1,0,0,0,0,  7,0,0), "arst_adv1");
        a_en = 0;
        #1 rst_n = 1'b0;
        #1;
        check("arst.out_now",  32'(a_out),  0);
        check("arst.lsz_now",  32'(a_lsz),  0);
        check("arst.wrap_now", 32'(a_wrap), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step_a(mk(1,0,0,0,0,  8,1,0), "arst_post0");
        step_a(mk(1,0,0,0,0, 12,0,0), "arst_post1");
        step_a(mk(1,0,0,0,0,  4,2,0), "arst_post2");
        idle_all();

        // Randomized run on the WIDTH=6 instance, including out-of-range writes.
        do_reset();
        for (int k = 0; k < BW; k++) mv[k] = BW'(1 << (BW - 1 - k));
        mcnt = 0;
        mout = '0;
        check("rnd.reset_out", 32'(b_out), 0);
        for (int c = 0; c < 1500; c++) begin
            logic          en, clr, wen;
            logic [BL-1:0] waddr;
            logic [BW-1:0] wdata;
            en    = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 39) == 0);
            wen   = ($urandom_range(0, 9) == 0);
            waddr = BL'($urandom_range(0, 7));
            wdata = BW'($urandom);
            b_en = en; b_clr = clr; b_wen = wen; b_waddr = waddr; b_wdata = wdata;

            mwrap = 1'b0;
            if (clr) begin
                mcnt = 0;
                mout = '0;
            end else if (en) begin
                if (mcnt == (1 << BW) - 1) begin
                    mcnt  = 0;
                    mout  = '0;
                    mwrap = 1'b1;
                end else begin
                    mout = mout ^ mv[trailing_ones(mcnt)];
                    mcnt = mcnt + 1;
                end
            end
            if (wen && int'(waddr) < BW) mv[waddr] = wdata;

            @(posedge clk);
            #2;
            check($sformatf("rnd[%0d].out", c),  32'(b_out),  32'(mout));
            check($sformatf("rnd[%0d].lsz", c),  32'(b_lsz),  32'(trailing_ones(mcnt)));
            check($sformatf("rnd[%0d].wrap", c), 32'(b_wrap), 32'(mwrap));
        end
        idle_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sobol_seq_gen.md
# sobol_seq_gen

Sequential Sobol low-discrepancy sequence generator for unary/stochastic bitstream sources. Consumes the least-significant-zero (LSZ) index of an internal counter. Each advance XORs the selected direction vector into the running sample (Gray-code Sobol). Feeds the comparator stage of a stochastic number generator, one WIDTH-bit sample per advance.

## Interface

- WIDTH, 8, sample and counter width in bits (≥2)
- LOGWIDTH, 3, index width, $clog2(WIDTH)

Ports:

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  advance sequence by one sample this cycle
- clear  in  1  synchronous restart to sample 0
- dv_wr_en  in  1  direction-vector write strobe
- dv_wr_addr  in  LOGWIDTH  direction-vector index
- dv_wr_data  in  WIDTH  direction-vector value
- out  out  WIDTH  current Sobol sample (registered)
- lsz_idx  out  LOGWIDTH  LSZ index of current counter (combinational from counter register)
- wrap  out  1  one-cycle pulse: the sequence wrapped to 0 on the previous edge

## Operation

- State: counter cnt[WIDTH], sample register out, direction-vector file V[0..WIDTH-1] of WIDTH bits each, wrap register.
- lsz_idx is the lowest bit position of cnt that is 0. If cnt is all ones, lsz_idx = WIDTH-1.
- Advance (enable=1, clear=0):
  - cnt not all ones: out ← out ^ V[lsz_idx], cnt ← cnt+1, wrap ← 0.
  - cnt all ones: out ← 0, cnt ← 0, wrap ← 1. The period is 2^WIDTH samples.
- Idle (enable=0, clear=0): cnt and out hold; wrap ← 0.
- clear=1 has priority over enable: cnt ← 0, out ← 0, wrap ← 0. V is not affected.
- Direction-vector write: if dv_wr_en=1 and dv_wr_addr < WIDTH, then V[dv_wr_addr] ← dv_wr_data. Writes with addr ≥ WIDTH are ignored.
- Write and advance in the same cycle: the XOR uses the old V value; the new value is used from the next cycle.
- Write and clear in the same cycle: both take effect.
- Reset values: cnt=0, out=0, wrap=0, V[k] = 1 << (WIDTH-1-k) (van der Corput). lsz_idx=0 after reset.

## Timing

- Single clock domain; all state updates on the rising clk edge.
- rst_n assertion clears all state immediately, independent of clk. Deassertion is synchronous to clk; the first advance is taken on the first edge with rst_n=1.
- Latency:
  - enable sampled at edge N → new out valid after edge N.
  - wrap is high for exactly the cycle following the wrapping edge.
- Throughput: one sample per cycle with enable held high; no bubbles at wrap.
- Reset asserted mid-sequence discards cnt, out and any loaded V; vectors revert to defaults.

## Structure

- Package sobol_pkg:
  - default WIDTH/LOGWIDTH constants;
  - function default_dv(k, width) returning 1 << (width-1-k).
- Sub-module sobol_lsz: purely combinational, cnt[WIDTH] → lsz_idx[LOGWIDTH], priority encoder on ~cnt, all-ones → WIDTH-1. Instantiated once; the top module holds all registers.

## Test plan

- Reset, WIDTH=4, enable held high for 9 cycles → out sequence 0,8,12,4,6,14,10,2,3,11; lsz_idx sequence 0,1,0,2,0,1,0,3,...
- WIDTH=4, 16 consecutive advances from reset → out=0, cnt=0, wrap pulses high for one cycle; all 16 values 0..15 appear exactly once before the wrap.
- Toggle enable 1,0,0,1 from reset → out 0→8, holds 8 for two cycles, then 12; wrap stays 0.
- clear and enable both high after 5 advances → out=0, next advance gives 8; V unchanged.
- Write V[0]=4'h3 with enable=1 in the same cycle from reset → out=8 (old V); the next advance at cnt=1 uses V[1] → 12; the advance at cnt=2 uses the new V[0] → 12^3=15.
- Assert rst_n low asynchronously mid-cycle after loading V[1]=4'hF → out=0 immediately; after release, the sequence matches the default 0,8,12,…
